// File: rtl/branch_redirect_pc_if.sv
// Execute-stage branch/jump bus between the pipeline and branch_redirect_pc.
// Build with BRANCH_STATS_EN defined to add the br_total/br_taken counters.
interface branch_redirect_pc_if;
    // valid_ex qualifies every execute field; there is no back-pressure path,
    // stall only freezes the fetch PC and never blocks a redirect.
    logic        stall;
    logic        valid_ex;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic        br_eq;
    logic        br_lt;
    logic [31:0] pc_ex;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        brun_sel;
    logic [31:0] pc;
    logic        taken;
    logic        flush;
    logic        misalign;
    logic        fsm_state;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_total;
    logic [31:0] br_taken;

    modport slave (
        input  stall, valid_ex, is_branch, is_jal, is_jalr, funct3, br_eq, br_lt,
        input  pc_ex, imm, rs1_data,
        output brun_sel, pc, taken, flush, misalign, fsm_state, br_total, br_taken
    );
    modport master (
        output stall, valid_ex, is_branch, is_jal, is_jalr, funct3, br_eq, br_lt,
        output pc_ex, imm, rs1_data,
        input  brun_sel, pc, taken, flush, misalign, fsm_state, br_total, br_taken
    );
`else
    modport slave (
        input  stall, valid_ex, is_branch, is_jal, is_jalr, funct3, br_eq, br_lt,
        input  pc_ex, imm, rs1_data,
        output brun_sel, pc, taken, flush, misalign, fsm_state
    );
    modport master (
        output stall, valid_ex, is_branch, is_jal, is_jalr, funct3, br_eq, br_lt,
        output pc_ex, imm, rs1_data,
        input  brun_sel, pc, taken, flush, misalign, fsm_state
    );
`endif
endinterface

// File: rtl/branch_redirect_pc.sv
// Branch/jump resolution, fetch PC register and post-redirect flush sequencer.
// Optional BRANCH_STATS_EN adds branch total/taken counters.
module branch_redirect_pc #(
    parameter logic [31:0] RESET_PC     = 32'h0100_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic                 clock,
    input logic                 reset,
    branch_redirect_pc_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state;
    logic [2:0]  flush_cnt;
    logic [31:0] pc_q;
    logic        flush_q;
    logic        misalign_q;

    logic        cond;
    logic        brun_sel_c;
    logic [31:0] target;
    logic        req;
    logic        bad_target;
    logic        taken_c;

    always_comb begin
        brun_sel_c = (bus.funct3[2:1] == 2'b11);
        cond = 1'b0;
        case (bus.funct3)
            3'b000:          cond = bus.br_eq;
            3'b001:          cond = !bus.br_eq;
            3'b100, 3'b110:  cond = bus.br_lt;
            3'b101, 3'b111:  cond = !bus.br_lt;
            default:         cond = 1'b0;
        endcase

        if (bus.is_jalr)
            target = (bus.rs1_data + bus.imm) & ~32'h1;
        else
            target = bus.pc_ex + bus.imm;

        req = bus.valid_ex && (state == IDLE) &&
              (bus.is_jal || bus.is_jalr || (bus.is_branch && cond));
        // A word-misaligned target is reported instead of followed.
        bad_target = req && target[1];
        taken_c    = req && !target[1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            state      <= IDLE;
            flush_cnt  <= 3'd0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (taken_c)
                pc_q <= target;
            else if (!bus.stall)
                pc_q <= pc_q + 32'd4;

            if (bad_target)
                misalign_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (taken_c) begin
                        state     <= FLUSH;
                        flush_cnt <= 3'(FLUSH_CYCLES - 1);
                        flush_q   <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_total_q;
    logic [31:0] br_taken_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            br_total_q <= 32'd0;
            br_taken_q <= 32'd0;
        end else if (bus.valid_ex && bus.is_branch && (state == IDLE)) begin
            br_total_q <= br_total_q + 32'd1;
            if (taken_c)
                br_taken_q <= br_taken_q + 32'd1;
        end
    end

    assign bus.br_total = br_total_q;
    assign bus.br_taken = br_taken_q;
`endif

    assign bus.brun_sel  = brun_sel_c;
    assign bus.taken     = taken_c;
    assign bus.pc        = pc_q;
    assign bus.flush     = flush_q;
    assign bus.misalign  = misalign_q;
    assign bus.fsm_state = state;
endmodule

// File: doc/branch_redirect_pc.md
Name: branch_redirect_pc

Overview:
- Execute-stage consumer of the branch comparator's br_eq/br_lt.
- Drives the comparator's signed/unsigned select from funct3, resolves branch/jump direction and target, and owns the fetch PC register.
- Runs a flush sequencer that squashes wrong-path instructions after every redirect.

Parameters:
RESET_PC, 32'h01000000, PC value loaded on reset
FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect (legal 1..7)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC (hazard/memory stall)
valid_ex  in  1  instruction in execute is valid
is_branch  in  1  execute instruction is a conditional branch (opcode 1100011)
is_jal  in  1  execute instruction is JAL
is_jalr  in  1  execute instruction is JALR
funct3  in  3  execute instruction funct3
br_eq  in  1  comparator equal result
br_lt  in  1  comparator less-than result
pc_ex  in  32  PC of execute instruction
imm  in  32  sign-extended immediate
rs1_data  in  32  rs1 operand (JALR base)
brun_sel  out  1  comparator select: 1 = unsigned, 0 = signed
pc  out  32  current fetch PC
taken  out  1  combinational: redirect condition this cycle
flush  out  1  squash fetch/decode
misalign  out  1  sticky misaligned-target flag

Behaviour:
- Reset, asynchronous: pc=RESET_PC, flush=0, misalign=0, flush counter=0, state=IDLE.
- brun_sel, combinational: 1 when funct3 is 110 (BLTU) or 111 (BGEU); 0 otherwise, including non-branches.
- Condition, combinational, by funct3:
  - 000 BEQ = br_eq
  - 001 BNE = !br_eq
  - 100 BLT / 110 BLTU = br_lt
  - 101 BGE / 111 BGEU = !br_lt
  - 010/011 = 0 (not taken)
- Target, 32-bit wrapping add:
  - branch/JAL: pc_ex+imm
  - JALR: (rs1_data+imm) & ~32'h1
  - More than one of is_branch/is_jal/is_jalr set: priority jalr > jal > branch.
- req = valid_ex & state==IDLE & (is_jal | is_jalr | (is_branch & condition)).
- Misaligned target: target[1]==1 with req set.
  - taken=0, no redirect, pc follows normal stall/+4 rule.
  - misalign set next edge; held until reset.
- taken = req & !misaligned target.
- PC register update, per rising edge:
  - taken: pc<=target. Redirect overrides stall.
  - else !stall: pc<=pc+4, wraps 32'hFFFFFFFC -> 0.
  - else: hold.
- State machine:
  - IDLE: flush=0. taken -> FLUSH, counter<=FLUSH_CYCLES-1, flush=1 from the next cycle.
  - FLUSH: flush=1; valid_ex ignored, so taken=0. Counter decrements each cycle, independent of stall. At counter==0 return to IDLE, so flush is high exactly FLUSH_CYCLES cycles.
- Reset mid-flush: immediately returns to IDLE, flush=0.
- Latency:
  - taken/brun_sel: combinational, same cycle.
  - pc: 1 cycle after taken.
  - flush: rises the cycle pc shows the target.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds outputs br_total[31:0] and br_taken[31:0].
  - br_total counts cycles with valid_ex & is_branch & state==IDLE.
  - br_taken counts those with taken=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, stall=0, no valid_ex -> pc=01000000, 01000004, 01000008 on successive cycles; flush=0.
- BLTU (funct3=110), br_lt=1, pc_ex=01000010, imm=-16 -> brun_sel=1, taken=1; next cycle pc=01000000, flush=1 for exactly 2 cycles; valid_ex branch during flush is ignored.
- BGE (funct3=101), br_lt=1 -> brun_sel=0, taken=0; pc advances +4. With stall=1 it holds.
- JALR rs1_data=01000101, imm=4, stall=1 -> pc=01000104 next cycle (LSB cleared, stall overridden).
- JAL pc_ex=01000000, imm=6 -> target 01000006: misalign=1 (sticky), no redirect, no flush; reset clears misalign.
- Assert reset during second flush cycle -> flush=0 and pc=RESET_PC immediately. With BRANCH_STATS_EN: 3 branches (2 taken) -> br_total=3, br_taken=2.
